// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline sequencer: stall bit positions, stall patterns,
// exception codes and FSM state encodings.
package pipeline_ctrl_pkg;

    localparam int unsigned STALL_PC = 0;
    localparam int unsigned STALL_WB = 5;
    localparam int unsigned STALL_W  = STALL_WB + 1;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ALL  = 6'b111111;

    typedef enum logic [2:0] {
        ExcGeneric = 3'd0,
        ExcSyscall = 3'd1,
        ExcBreak   = 3'd2,
        ExcRi      = 3'd3,
        ExcOvf     = 3'd4,
        ExcInt     = 3'd5,
        ExcEret    = 3'd6,
        ExcGeneric7 = 3'd7
    } exc_type_e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StWaitBus = 2'd1,
        StFlush   = 2'd2
    } state_e;

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges stage stall requests, sequences exception/ERET redirects
// behind in-flight bus transactions, and counts stalled cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_if,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               stallreq_mem,
    input  logic               excp_valid,
    input  logic [2:0]         excp_type,
    input  logic [31:0]        epc_i,
    input  logic               cnt_clr,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic [CNT_W-1:0]   stall_cnt
);

    state_e      state_q;
    logic [2:0]  type_q;
    logic [31:0] epc_q;

    function automatic logic [31:0] redirect_pc(input logic [2:0] t, input logic [31:0] epc);
        return (t == 3'(ExcEret)) ? epc : EXC_VECTOR;
    endfunction

    // An exception seen in RUN takes over the cycle, so no stall is raised for it.
    always_comb begin
        stall = STALL_NONE;
        if (!rst) begin
            unique case (state_q)
                StRun: begin
                    if (!excp_valid) begin
                        if (stallreq_mem)     stall = STALL_MEM;
                        else if (stallreq_ex) stall = STALL_EX;
                        else if (stallreq_id) stall = STALL_ID;
                        else if (stallreq_if) stall = STALL_IF;
                        else                  stall = STALL_NONE;
                    end
                end
                StWaitBus: stall = STALL_ALL;
                StFlush:   stall = STALL_NONE;
                default:   stall = STALL_NONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            flush   <= 1'b0;
            new_pc  <= '0;
            type_q  <= '0;
            epc_q   <= '0;
        end else begin
            flush <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (excp_valid) begin
                        type_q <= excp_type;
                        epc_q  <= epc_i;
                        if (stallreq_mem) begin
                            state_q <= StWaitBus;
                        end else begin
                            state_q <= StFlush;
                            flush   <= 1'b1;
                            new_pc  <= redirect_pc(excp_type, epc_i);
                        end
                    end
                end
                StWaitBus: begin
                    if (!stallreq_mem) begin
                        state_q <= StFlush;
                        flush   <= 1'b1;
                        new_pc  <= redirect_pc(type_q, epc_q);
                    end
                end
                StFlush: state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall[STALL_PC] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed vector table, counter sequences and randomized
// stimulus against a behavioural model.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, sif, sid, sex, smem, ev, clr;
    logic [2:0]  et;
    logic [31:0] epc;
    logic [5:0]  stall, stall4;
    logic        flush, flush4;
    logic [31:0] new_pc, new_pc4;
    logic [31:0] cnt;
    logic [3:0]  cnt4;

    int checks   = 0;
    int failures = 0;
    bit mchk     = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.EXC_VECTOR(32'h0000_0020), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
        .stallreq_mem(smem), .excp_valid(ev), .excp_type(et), .epc_i(epc), .cnt_clr(clr),
        .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cnt(cnt)
    );

    pipeline_ctrl #(.EXC_VECTOR(32'h0000_0020), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
        .stallreq_mem(smem), .excp_valid(ev), .excp_type(et), .epc_i(epc), .cnt_clr(clr),
        .stall(stall4), .flush(flush4), .new_pc(new_pc4), .stall_cnt(cnt4)
    );

    // Behavioural model: a pending redirect either waits for the bus or is being flushed.
    bit          m_wait, m_flush;
    logic [31:0] m_pc, m_epc;
    logic [2:0]  m_type;
    longint      m_cnt;
    int          m_cnt4;

    function automatic logic [31:0] m_redirect(input logic [2:0] t, input logic [31:0] e);
        return (t == 3'd6) ? e : 32'h0000_0020;
    endfunction

    function automatic logic [5:0] m_stall();
        int k;
        if (rst || m_flush) return 6'd0;
        if (m_wait) return 6'h3f;
        if (ev) return 6'd0;
        k = smem ? 5 : sex ? 4 : sid ? 3 : sif ? 2 : 0;
        return 6'((1 << k) - 1);
    endfunction

    task automatic model_update();
        logic [5:0] s;
        bit nf;
        s = m_stall();
        if (rst) begin
            m_wait = 0; m_flush = 0; m_pc = 0; m_epc = 0; m_type = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (clr) begin
                m_cnt = 0; m_cnt4 = 0;
            end else if (s[0]) begin
                if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            nf = 0;
            if (m_flush) begin
                nf = 0;
            end else if (m_wait) begin
                if (!smem) begin
                    m_wait = 0; nf = 1; m_pc = m_redirect(m_type, m_epc);
                end
            end else if (ev) begin
                m_type = et; m_epc = epc;
                if (smem) m_wait = 1;
                else begin nf = 1; m_pc = m_redirect(et, epc); end
            end
            m_flush = nf;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        if (mchk) begin
            chk("model_stall", 32'(stall), 32'(m_stall()));
            chk("model_flush", 32'(flush), 32'(m_flush));
            chk("model_new_pc", new_pc, m_pc);
            chk("model_cnt", cnt, 32'(m_cnt));
            chk("model_cnt4", 32'(cnt4), 32'(m_cnt4));
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; sif = 0; sid = 0; sex = 0; smem = 0; ev = 0; et = 0; epc = 0; clr = 0;
    endtask

    typedef struct {
        logic        rst, sif, sid, sex, smem, ev;
        logic [2:0]  et;
        logic [31:0] epc;
        logic        clr;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic a, input logic b, input logic c,
                                input logic d, input logic v, input logic [2:0] t,
                                input logic [31:0] e, input logic k, input logic [5:0] es,
                                input logic ef, input logic [31:0] ep, input logic [31:0] ec);
        vec_t x;
        x.rst = r; x.sif = a; x.sid = b; x.sex = c; x.smem = d; x.ev = v; x.et = t;
        x.epc = e; x.clr = k; x.e_stall = es; x.e_flush = ef; x.e_pc = ep; x.e_cnt = ec;
        return x;
    endfunction

    vec_t vecs[25];

    initial begin
        //             rst if id ex mem ev type epc            clr stall  fl pc            cnt
        vecs[0]  = mk(0, 1, 1, 1, 1, 0, 0, 32'h0,          0, 6'h1f, 0, 32'h0,        0);
        vecs[1]  = mk(0, 1, 1, 1, 0, 0, 0, 32'h0,          0, 6'h0f, 0, 32'h0,        1);
        vecs[2]  = mk(0, 1, 1, 0, 0, 0, 0, 32'h0,          0, 6'h07, 0, 32'h0,        2);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,          0, 6'h03, 0, 32'h0,        3);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 0, 32'h0,        4);
        vecs[5]  = mk(0, 1, 1, 0, 0, 1, 4, 32'h0,          0, 6'h00, 0, 32'h0,        4);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 1, 32'h20,       4);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 0, 32'h20,       4);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 6, 32'h0040_1234,  0, 6'h00, 0, 32'h20,       4);
        vecs[9]  = mk(0, 0, 1, 0, 0, 0, 6, 32'hdead_beef,  0, 6'h00, 1, 32'h0040_1234, 4);
        vecs[10] = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,          0, 6'h07, 0, 32'h0040_1234, 4);
        vecs[11] = mk(0, 0, 0, 0, 1, 1, 1, 32'h0,          0, 6'h00, 0, 32'h0040_1234, 5);
        vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,          0, 6'h3f, 0, 32'h0040_1234, 5);
        vecs[13] = mk(0, 1, 0, 0, 1, 1, 6, 32'h0,          0, 6'h3f, 0, 32'h0040_1234, 6);
        vecs[14] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,          0, 6'h3f, 0, 32'h0040_1234, 7);
        vecs[15] = mk(0, 0, 1, 0, 0, 0, 0, 32'h0,          0, 6'h3f, 0, 32'h0040_1234, 8);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 1, 32'h20,       9);
        vecs[17] = mk(0, 0, 0, 0, 0, 1, 5, 32'h0,          0, 6'h00, 0, 32'h20,       9);
        vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 1, 32'h20,       9);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 0, 32'h20,       9);
        vecs[20] = mk(0, 0, 0, 0, 1, 1, 6, 32'h0000_1000,  0, 6'h00, 0, 32'h20,       9);
        vecs[21] = mk(0, 0, 0, 0, 1, 0, 0, 32'h0,          0, 6'h3f, 0, 32'h20,       9);
        vecs[22] = mk(1, 0, 0, 0, 1, 0, 0, 32'h0,          0, 6'h00, 0, 32'h20,       10);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 0, 32'h0,        0);
        vecs[24] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,          0, 6'h00, 0, 32'h0,        0);

        idle_inputs();
        rst = 1;
        repeat (2) begin
            @(posedge clk);
            model_update();
        end
        #1;
        rst = 0;
        mchk = 1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; sif = vecs[i].sif; sid = vecs[i].sid; sex = vecs[i].sex;
            smem = vecs[i].smem; ev = vecs[i].ev; et = vecs[i].et; epc = vecs[i].epc;
            clr = vecs[i].clr;
            @(negedge clk);
            chk_model();
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_cnt", i), cnt, vecs[i].e_cnt);
            @(posedge clk);
            model_update();
            #1;
        end

        // Counter: clear, five load-use stall cycles, clear during a stall, saturation.
        idle_inputs();
        clr = 1;
        step();
        clr = 0;
        sid = 1;
        repeat (5) step();
        sid = 0;
        @(negedge clk);
        chk("cnt_after_5", cnt, 32'd5);
        chk("cnt4_after_5", 32'(cnt4), 32'd5);
        @(posedge clk);
        model_update();
        #1;
        sid = 1; clr = 1;
        step();
        clr = 0;
        @(negedge clk);
        chk("cnt_clr_prio", cnt, 32'd0);
        @(posedge clk);
        model_update();
        #1;
        repeat (19) step();
        sid = 0;
        @(negedge clk);
        chk("cnt4_saturate", 32'(cnt4), 32'h0000_000f);
        chk("cnt_no_saturate", cnt, 32'd20);
        @(posedge clk);
        model_update();
        #1;

        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(63) == 0);
            sif  = ($urandom_range(2) == 0);
            sid  = ($urandom_range(2) == 0);
            sex  = ($urandom_range(3) == 0);
            if ($urandom_range(3) == 0) smem = ~smem;
            ev   = ($urandom_range(7) == 0);
            et   = 3'($urandom_range(7));
            if ($urandom_range(1) == 0) et = 3'd6;
            epc  = $urandom;
            clr  = ($urandom_range(31) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. It merges per-stage stall requests into the 6-bit stall vector consumed by PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It sequences exception/ERET redirection: it waits out an in-flight data-bus transaction, then issues a one-cycle flush with the redirect PC. It also keeps a saturating stall-cycle performance counter.

Parameters:
EXC_VECTOR, 32'h0000_0020, redirect PC for all non-ERET exception types
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  system clock, all state on posedge
rst  in  1  synchronous reset, active-high (`ENABLE)
stallreq_if  in  1  instruction bus busy
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multi-cycle EX op (DIV/MADD) busy
stallreq_mem  in  1  data bus transaction in progress
excp_valid  in  1  exception detected in MEM stage, sampled once per cycle
excp_type  in  3  exception code: 1 SYSCALL, 2 BREAK, 3 RI, 4 OVF, 5 INT, 6 ERET, 0/7 treated as generic
epc_i  in  32  CP0 EPC value, used for ERET
cnt_clr  in  1  clear stall counter
stall  out  6  [0] PC, [1] IF_ID, [2] ID_EX, [3] EX_MEM, [4] MEM_WB, [5] WB hold
flush  out  1  registered one-cycle flush pulse to all pipeline registers
new_pc  out  32  redirect PC, valid while flush=1
stall_cnt  out  CNT_W  cycles with stall[0]=1

Behaviour:
- Reset (rst=1 at posedge): state=RUN, flush=0, new_pc=0, stall_cnt=0, latched type/epc=0. stall is forced to 6'b000000 while rst=1.
- States: RUN, WAIT_BUS, FLUSH. Encodings live in defines.v.
- RUN stall (combinational, highest priority first):
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
  - Consequence: MEM_WB inserts a bubble only for the mem stall (stall[4]=1, stall[5]=0).
- RUN, excp_valid=1:
  - Latch excp_type and epc_i.
  - If stallreq_mem=1 the same cycle: go to WAIT_BUS.
  - Otherwise: go to FLUSH.
  - The exception overrides all stall requests in that cycle; stall follows the target state from the next cycle.
- WAIT_BUS:
  - stall=6'b111111 (full freeze, no bubbles).
  - Stay while stallreq_mem=1; go to FLUSH on the first cycle it is 0.
  - excp_valid and other requests are ignored.
- FLUSH:
  - flush=1 for exactly one cycle.
  - new_pc = latched epc for type 6, else EXC_VECTOR.
  - stall=6'b000000; all inputs ignored.
  - Next state RUN; flush returns to 0 and new_pc holds its value.
- Latency: excp_valid sampled at edge N with no bus busy gives flush=1 in cycle N+1. With bus busy, flush=1 one cycle after the edge on which stallreq_mem is first seen 0.
- Back-to-back exceptions: excp_valid in the RUN cycle immediately after FLUSH is a new exception and is handled normally.
- stall_cnt:
  - Increments each cycle stall[0]=1, including WAIT_BUS.
  - Saturates at all-ones.
  - cnt_clr has priority over increment; rst has priority over both.
- Reset during WAIT_BUS or FLUSH: returns to RUN with flush=0 on the next edge. No pending redirect is kept.

Decomposition:
- defines.v gains: stall bit indices (STALL_PC..STALL_WB), exception type codes, EXC_VECTOR default, state encodings.
- Single flat module, no sub-module. The stall encoder stays inline as a priority case.

Test Plan:
- Priority: stallreq_if=id=ex=mem=1 in RUN -> stall=6'b011111. Drop mem -> 6'b001111. Drop ex -> 6'b000111. Drop id -> 6'b000011.
- Plain exception: excp_valid=1, type=4 at edge N -> flush=1 and new_pc=32'h00000020 in cycle N+1 only; stall=0 in that cycle; RUN in N+2.
- ERET: excp_valid=1, type=6, epc_i=32'h0040_1234 -> flush pulse with new_pc=32'h0040_1234. Changing epc_i after the sampling edge has no effect.
- Bus wait: excp_valid=1 with stallreq_mem=1 held 3 more cycles -> stall=6'b111111 for those cycles, then a flush pulse one cycle after mem drops.
- Counter: 5 cycles of stallreq_id -> stall_cnt=5. cnt_clr concurrent with a stall cycle -> 0. Preload near all-ones with CNT_W=4 -> holds 4'hF.
- Reset mid-sequence: rst=1 during WAIT_BUS -> next cycle state RUN, flush=0, stall=0, stall_cnt=0, no flush after rst drops.
